// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM test datapath: the test FSM state codes
// (used to decode rec_state in logged records) and the record width helper.
package ram_test_pkg;

   // State codes reported by the RAM test FSM on error_state.
   localparam logic [7:0] ST_START        = 8'd1;
   localparam logic [7:0] ST_INIT_WRITE   = 8'd2;
   localparam logic [7:0] ST_INIT_NEXT    = 8'd3;
   localparam logic [7:0] ST_UP_READ      = 8'd4;
   localparam logic [7:0] ST_UP_WRITE     = 8'd5;
   localparam logic [7:0] ST_UP_VERIFY    = 8'd6;
   localparam logic [7:0] ST_UP_NEXT      = 8'd7;
   localparam logic [7:0] ST_DOWN_READ    = 8'd8;
   localparam logic [7:0] ST_DOWN_WRITE   = 8'd9;
   localparam logic [7:0] ST_DOWN_VERIFY  = 8'd10;
   localparam logic [7:0] ST_DOWN_NEXT    = 8'd11;
   localparam logic [7:0] ST_FINAL_READ   = 8'd12;
   localparam logic [7:0] ST_RESTART_LOOP = 8'd13;

   // Width of one packed error record:
   // {state(8), address, expected, actual, loop_count}.
   function automatic int rec_width(input int addr_width, input int data_width,
                                    input int count_width);
      return 8 + addr_width + 2 * data_width + count_width;
   endfunction

endpackage

// File: rtl/ram_test_err_fifo.sv
// Synchronous FIFO with a registered show-ahead head. The head register is
// reloaded every cycle from the entry that will be at the front after this
// cycle's pop, so a record written at edge N is presented after edge N+1.
// When full, a push is still accepted if the head is popped on the same cycle.
module ram_test_err_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_next;
   logic [CW-1:0]    count;
   logic             head_valid;
   logic             pop_ok;
   logic             push_ok;

   // count tracks entries in storage; head_valid lags it by one cycle because
   // the head register needs a cycle to pick up a freshly written entry.
   assign full    = (count == DEPTH_L);
   assign empty   = !head_valid;
   assign pop_ok  = pop && head_valid;
   assign push_ok = push && (!full || pop_ok);
   assign rd_next = rd_ptr + PW'(pop_ok);

   // Pointer, occupancy and head-valid bookkeeping; flush behaves like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr     <= rd_next;
         count      <= count + CW'(push_ok) - CW'(pop_ok);
         head_valid <= (count - CW'(pop_ok)) != '0;
      end
   end

   // Storage write and show-ahead head register load (no reset needed).
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
      dout <= mem[rd_next];
   end

endmodule

// File: rtl/ram_test_error_logger.sv
// Error logger sitting behind the RAM test FSM. Counts completed loops,
// error cycles and dropped records (all saturating), keeps sticky flags,
// and queues one record per error cycle for the reporting stage.
//
// Record port handshake: rec_valid stays high while a head record exists and
// rec_* hold that record stable; a record is consumed on each clock edge where
// rec_valid && rec_ready. rec_ready has no effect while rec_valid is low, and
// rec_* carry no meaning then.
module ram_test_error_logger
   import ram_test_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int DATA_WIDTH  = 1,
   parameter int LOG_DEPTH   = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   loop_complete,
   input  logic                   error,
   input  logic [7:0]             error_state,
   input  logic [ADDR_WIDTH-1:0]  error_address,
   input  logic [DATA_WIDTH-1:0]  expected_data,
   input  logic [DATA_WIDTH-1:0]  actual_data,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [7:0]             rec_state,
   output logic [ADDR_WIDTH-1:0]  rec_address,
   output logic [DATA_WIDTH-1:0]  rec_expected,
   output logic [DATA_WIDTH-1:0]  rec_actual,
   output logic [COUNT_WIDTH-1:0] rec_loop,
   output logic [COUNT_WIDTH-1:0] loop_count,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic [COUNT_WIDTH-1:0] dropped_count,
   output logic                   overflow,
   output logic                   any_error
);

   localparam int REC_W = rec_width(ADDR_WIDTH, DATA_WIDTH, COUNT_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             drop;
   logic [REC_W-1:0] push_rec;
   logic [REC_W-1:0] head_rec;

   // loop_count here is the value before any same-cycle loop_complete.
   assign push_rec  = {error_state, error_address, expected_data, actual_data, loop_count};
   assign rec_valid = !fifo_empty;
   assign pop       = rec_valid && rec_ready;
   assign drop      = error && fifo_full && !pop;
   assign {rec_state, rec_address, rec_expected, rec_actual, rec_loop} = head_rec;

   ram_test_err_fifo #(
      .WIDTH (REC_W),
      .DEPTH (LOG_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear),
      .push  (error),
      .din   (push_rec),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (head_rec)
   );

   // Saturating counters and sticky flags; clear acts as a local reset.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         loop_count    <= '0;
         error_count   <= '0;
         dropped_count <= '0;
         overflow      <= 1'b0;
         any_error     <= 1'b0;
      end else begin
         if (loop_complete && loop_count != CNT_MAX) loop_count <= loop_count + 1'b1;
         if (error) begin
            any_error <= 1'b1;
            if (error_count != CNT_MAX) error_count <= error_count + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (dropped_count != CNT_MAX) dropped_count <= dropped_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_test_error_logger.sv
// Directed bench for ram_test_error_logger: default instance plus a
// COUNT_WIDTH=4 instance for the saturation boundary.
module tb_ram_test_error_logger;
   import ram_test_pkg::*;

   localparam int REC_W  = 32;  // 8 + 6 + 1 + 1 + 16
   localparam int REC4_W = 20;  // 8 + 6 + 1 + 1 + 4

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus
   logic       loop_complete = 1'b0;
   logic       error = 1'b0;
   logic [7:0] error_state = '0;
   logic [5:0] error_address = '0;
   logic [0:0] expected_data = '0;
   logic [0:0] actual_data = '0;
   logic       rec_ready = 1'b0;
   logic       loop_complete4 = 1'b0;
   logic       error4 = 1'b0;
   logic       rec_ready4 = 1'b0;

   // default instance outputs
   logic        rec_valid, overflow, any_error;
   logic [7:0]  rec_state;
   logic [5:0]  rec_address;
   logic [0:0]  rec_expected, rec_actual;
   logic [15:0] rec_loop, loop_count, error_count, dropped_count;

   // COUNT_WIDTH=4 instance outputs
   logic       rec_valid4, overflow4, any_error4;
   logic [7:0] rec_state4;
   logic [5:0] rec_address4;
   logic [0:0] rec_expected4, rec_actual4;
   logic [3:0] rec_loop4, loop_count4, error_count4, dropped_count4;

   ram_test_error_logger dut (
      .clk(clk), .rst(rst), .clear(clear),
      .loop_complete(loop_complete), .error(error), .error_state(error_state),
      .error_address(error_address), .expected_data(expected_data), .actual_data(actual_data),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_state(rec_state),
      .rec_address(rec_address), .rec_expected(rec_expected), .rec_actual(rec_actual),
      .rec_loop(rec_loop), .loop_count(loop_count), .error_count(error_count),
      .dropped_count(dropped_count), .overflow(overflow), .any_error(any_error)
   );

   ram_test_error_logger #(.COUNT_WIDTH(4)) dut_c4 (
      .clk(clk), .rst(rst), .clear(clear),
      .loop_complete(loop_complete4), .error(error4), .error_state(error_state),
      .error_address(error_address), .expected_data(expected_data), .actual_data(actual_data),
      .rec_valid(rec_valid4), .rec_ready(rec_ready4), .rec_state(rec_state4),
      .rec_address(rec_address4), .rec_expected(rec_expected4), .rec_actual(rec_actual4),
      .rec_loop(rec_loop4), .loop_count(loop_count4), .error_count(error_count4),
      .dropped_count(dropped_count4), .overflow(overflow4), .any_error(any_error4)
   );

   // scoreboard
   int n_checks = 0;
   int n_pass = 0;
   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] got;
   logic [REC_W-1:0] want;

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic pulse_loop();
      loop_complete = 1'b1;
      tick();
      loop_complete = 1'b0;
      tick();
   endtask

   task automatic set_fields(input logic [7:0] st, input logic [5:0] ad,
                             input logic ex, input logic ac);
      error_state   = st;
      error_address = ad;
      expected_data = ex;
      actual_data   = ac;
   endtask

   // Drain the whole scoreboard queue with rec_ready held high, one per cycle.
   task automatic drain_and_compare(input string tag);
      int n;
      n = exp_q.size();
      rec_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         want = exp_q.pop_front();
         got  = {rec_state, rec_address, rec_expected, rec_actual, rec_loop};
         n_checks++;
         if (rec_valid !== 1'b1 || got !== want)
            $display("FAIL %s_rec%0d valid=%b got=%h want=%h", tag, i, rec_valid, got, want);
         else n_pass++;
         tick();
      end
      rec_ready = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL %s_empty rec_valid got %b want 0", tag, rec_valid);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (loop_count !== 16'd0) $display("FAIL reset_loop_count got %0d want 0", loop_count);
      else n_pass++;
      n_checks++;
      if (error_count !== 16'd0) $display("FAIL reset_error_count got %0d want 0", error_count);
      else n_pass++;
      n_checks++;
      if (dropped_count !== 16'd0) $display("FAIL reset_dropped_count got %0d want 0", dropped_count);
      else n_pass++;
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL reset_rec_valid got %b want 0", rec_valid);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0 || any_error !== 1'b0)
         $display("FAIL reset_flags got ovf=%b any=%b want 0 0", overflow, any_error);
      else n_pass++;
      n_checks++;
      if (loop_count4 !== 4'd0 || rec_valid4 !== 1'b0)
         $display("FAIL reset_c4 got loop=%0d valid=%b want 0 0", loop_count4, rec_valid4);
      else n_pass++;
   endtask

   task automatic test_single_record();
      rec_ready = 1'b0;
      repeat (3) pulse_loop();
      set_fields(ST_UP_VERIFY, 6'h2A, 1'b1, 1'b0);
      error = 1'b1;
      tick();
      error = 1'b0;
      tick();
      n_checks++;
      if (rec_valid !== 1'b1) $display("FAIL single_rec_valid got %b want 1", rec_valid);
      else n_pass++;
      n_checks++;
      if (rec_state !== 8'd6 || rec_address !== 6'h2A)
         $display("FAIL single_state_addr got %0d/%h want 6/2a", rec_state, rec_address);
      else n_pass++;
      n_checks++;
      if (rec_expected !== 1'b1 || rec_actual !== 1'b0)
         $display("FAIL single_data got exp=%b act=%b want 1 0", rec_expected, rec_actual);
      else n_pass++;
      n_checks++;
      if (rec_loop !== 16'd3) $display("FAIL single_rec_loop got %0d want 3", rec_loop);
      else n_pass++;
      n_checks++;
      if (error_count !== 16'd1 || any_error !== 1'b1 || loop_count !== 16'd3)
         $display("FAIL single_counts got err=%0d any=%b loop=%0d want 1 1 3",
                  error_count, any_error, loop_count);
      else n_pass++;
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL single_pop rec_valid got %b want 0", rec_valid);
      else n_pass++;
   endtask

   task automatic test_same_cycle_loop();
      pulse_clear();
      set_fields(ST_DOWN_VERIFY, 6'h15, 1'b0, 1'b1);
      loop_complete = 1'b1;
      error = 1'b1;
      tick();
      loop_complete = 1'b0;
      error = 1'b0;
      tick();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_loop !== 16'd0 || rec_state !== 8'd10)
         $display("FAIL same_cycle_rec got valid=%b loop=%0d state=%0d want 1 0 10",
                  rec_valid, rec_loop, rec_state);
      else n_pass++;
      n_checks++;
      if (loop_count !== 16'd1) $display("FAIL same_cycle_loop_count got %0d want 1", loop_count);
      else n_pass++;
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [7:0] st;
      logic [5:0] ad;
      pulse_clear();
      rec_ready = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         st = 8'(i + 1);
         ad = 6'(i * 5 + 3);
         set_fields(st, ad, i[0], ~i[0]);
         if (i < 8) exp_q.push_back({st, ad, i[0], ~i[0], 16'd0});
         error = 1'b1;
         tick();
      end
      error = 1'b0;
      tick();
      n_checks++;
      if (dropped_count !== 16'd2) $display("FAIL ovf_dropped got %0d want 2", dropped_count);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow);
      else n_pass++;
      n_checks++;
      if (error_count !== 16'd10) $display("FAIL ovf_error_count got %0d want 10", error_count);
      else n_pass++;
      drain_and_compare("ovf");
   endtask

   task automatic test_full_push_pop();
      logic [7:0] st;
      logic [5:0] ad;
      pulse_clear();
      pulse_loop();
      rec_ready = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         st = 8'(13 - i);
         ad = 6'(40 + i);
         set_fields(st, ad, ~i[0], i[0]);
         exp_q.push_back({st, ad, ~i[0], i[0], 16'd1});
         error = 1'b1;
         tick();
      end
      error = 1'b0;
      tick();
      // head leaves and a new record enters on the same edge
      want = exp_q.pop_front();
      got  = {rec_state, rec_address, rec_expected, rec_actual, rec_loop};
      n_checks++;
      if (rec_valid !== 1'b1 || got !== want)
         $display("FAIL fullpp_head valid=%b got=%h want=%h", rec_valid, got, want);
      else n_pass++;
      set_fields(ST_RESTART_LOOP, 6'h3F, 1'b1, 1'b1);
      exp_q.push_back({ST_RESTART_LOOP, 6'h3F, 1'b1, 1'b1, 16'd1});
      error = 1'b1;
      rec_ready = 1'b1;
      tick();
      error = 1'b0;
      rec_ready = 1'b0;
      tick();
      n_checks++;
      if (dropped_count !== 16'd0 || overflow !== 1'b0)
         $display("FAIL fullpp_no_drop got dropped=%0d ovf=%b want 0 0", dropped_count, overflow);
      else n_pass++;
      n_checks++;
      if (error_count !== 16'd9) $display("FAIL fullpp_error_count got %0d want 9", error_count);
      else n_pass++;
      drain_and_compare("fullpp");
   endtask

   task automatic test_saturation();
      pulse_clear();
      for (int i = 0; i < 14; i++) begin
         loop_complete4 = 1'b1;
         tick();
         loop_complete4 = 1'b0;
         tick();
      end
      n_checks++;
      if (loop_count4 !== 4'd14) $display("FAIL sat_loop14 got %0d want 14", loop_count4);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         loop_complete4 = 1'b1;
         tick();
         loop_complete4 = 1'b0;
         tick();
      end
      n_checks++;
      if (loop_count4 !== 4'd15) $display("FAIL sat_loop20 got %0d want 15", loop_count4);
      else n_pass++;
      set_fields(ST_FINAL_READ, 6'h11, 1'b0, 1'b1);
      error4 = 1'b1;
      repeat (25) tick();
      error4 = 1'b0;
      tick();
      n_checks++;
      if (error_count4 !== 4'd15 || dropped_count4 !== 4'd15)
         $display("FAIL sat_err_drop got err=%0d drop=%0d want 15 15", error_count4, dropped_count4);
      else n_pass++;
      n_checks++;
      if (overflow4 !== 1'b1 || any_error4 !== 1'b1)
         $display("FAIL sat_flags got ovf=%b any=%b want 1 1", overflow4, any_error4);
      else n_pass++;
      n_checks++;
      if (rec_valid4 !== 1'b1 ||
          {rec_state4, rec_address4, rec_expected4, rec_actual4, rec_loop4} !==
          REC4_W'({8'd12, 6'h11, 1'b0, 1'b1, 4'd15}))
         $display("FAIL sat_rec got valid=%b rec=%h want 1 %h", rec_valid4,
                  {rec_state4, rec_address4, rec_expected4, rec_actual4, rec_loop4},
                  {8'd12, 6'h11, 1'b0, 1'b1, 4'd15});
      else n_pass++;
   endtask

   task automatic test_clear_mid_drain();
      pulse_clear();
      pulse_loop();
      pulse_loop();
      rec_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_fields(8'(i + 1), 6'(10 + i), 1'b1, 1'b0);
         error = 1'b1;
         tick();
      end
      error = 1'b0;
      tick();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_loop !== 16'd2)
         $display("FAIL clr_pre got valid=%b loop=%0d want 1 2", rec_valid, rec_loop);
      else n_pass++;
      rec_ready = 1'b1;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL clr_rec_valid got %b want 0", rec_valid);
      else n_pass++;
      n_checks++;
      if (loop_count !== 16'd0 || error_count !== 16'd0 || dropped_count !== 16'd0)
         $display("FAIL clr_counters got loop=%0d err=%0d drop=%0d want 0 0 0",
                  loop_count, error_count, dropped_count);
      else n_pass++;
      n_checks++;
      if (overflow !== 1'b0 || any_error !== 1'b0 || loop_count4 !== 4'd0 || overflow4 !== 1'b0)
         $display("FAIL clr_flags got ovf=%b any=%b loop4=%0d ovf4=%b want 0 0 0 0",
                  overflow, any_error, loop_count4, overflow4);
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if (rec_valid !== 1'b0) $display("FAIL clr_discarded rec_valid got %b want 0", rec_valid);
      else n_pass++;
      rec_ready = 1'b0;
      set_fields(ST_UP_WRITE, 6'h07, 1'b0, 1'b1);
      error = 1'b1;
      tick();
      error = 1'b0;
      tick();
      n_checks++;
      if (rec_valid !== 1'b1 || rec_loop !== 16'd0 || rec_address !== 6'h07 || rec_state !== 8'd5)
         $display("FAIL clr_new_rec got valid=%b loop=%0d addr=%h state=%0d want 1 0 07 5",
                  rec_valid, rec_loop, rec_address, rec_state);
      else n_pass++;
      n_checks++;
      if (error_count !== 16'd1) $display("FAIL clr_new_error_count got %0d want 1", error_count);
      else n_pass++;
   endtask

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_record();
      test_same_cycle_loop();
      test_overflow();
      test_full_push_pop();
      test_saturation();
      test_clear_mid_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
